// File: rtl/ps_if_pipe.sv
// Registered-ready pipeline slice for the ps_if bus: REQ_DEPTH skid stages on the
// request path, RSP_DEPTH on the response path. Optional counters: PS_IF_PIPE_STATS_EN.

module ps_if_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] main_q, skid_q;
  logic         rdy_q;
  logic         in_beat, out_take;
  logic         ld_main_in, ld_main_skid, ld_skid;

  assign in_beat   = in_valid & rdy_q;
  assign out_take  = (state != EMPTY) & out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY: if (in_beat) begin
        state_nxt  = ONE;
        ld_main_in = 1'b1;
      end
      ONE: begin
        if (in_beat && out_take) begin
          ld_main_in = 1'b1;
        end else if (in_beat) begin
          state_nxt = TWO;
          ld_skid   = 1'b1;
        end else if (out_take) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (out_take) begin
        // skid drains into main before anything newer can enter
        state_nxt    = ONE;
        ld_main_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      rdy_q  <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt != TWO);
      if (ld_main_in)   main_q <= in_data;
      if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)      skid_q <= in_data;
    end
  end

endmodule

module ps_if_pipe #(
  parameter int REQ_DEPTH = 1,
  parameter int RSP_DEPTH = 1,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int NW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold_valid,
  input  logic          in_slave_wvalid,
  input  logic          in_slave_arvalid,
  input  logic [AW-1:0] in_slave_waddr,
  input  logic [DW-1:0] in_slave_wdata,
  input  logic [AW-1:0] in_slave_raddr,
  input  logic [NW-1:0] in_slave_node_addr,
  output logic          in_slave_wready,
  output logic          in_slave_rvalid,
  output logic [DW-1:0] in_slave_rdata,
  input  logic          in_slave_rready,
  output logic          in_slave_wresp,
  output logic          in_master_wvalid,
  output logic          in_master_arvalid,
  output logic [AW-1:0] in_master_waddr,
  output logic [DW-1:0] in_master_wdata,
  output logic [AW-1:0] in_master_raddr,
  output logic [NW-1:0] in_master_node_addr,
  input  logic          in_master_wready,
  input  logic          in_master_rvalid,
  input  logic [DW-1:0] in_master_rdata,
  output logic          in_master_rready,
  input  logic          in_master_wresp,
  output logic          busy,
  output logic [31:0]   stat_req_cnt,
  output logic [31:0]   stat_rsp_cnt,
  output logic [31:0]   stat_stall_cnt
);

  typedef struct packed {
    logic          wvalid;
    logic          arvalid;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr;
    logic [NW-1:0] node_addr;
  } req_t;

  // index 0 is the upstream side, index DEPTH the downstream side of each chain
  logic [REQ_DEPTH:0]         rq_vld, rq_rdy;
  req_t [REQ_DEPTH:0]         rq_dat;
  logic [RSP_DEPTH:0]         rs_vld, rs_rdy;
  logic [RSP_DEPTH:0][DW-1:0] rs_dat;

  assign rq_vld[0]         = hold_valid & (in_slave_wvalid | in_slave_arvalid);
  assign rq_dat[0]         = '{wvalid: in_slave_wvalid, arvalid: in_slave_arvalid,
                               waddr: in_slave_waddr, wdata: in_slave_wdata,
                               raddr: in_slave_raddr, node_addr: in_slave_node_addr};
  assign rq_rdy[REQ_DEPTH] = in_master_wready;
  assign in_slave_wready   = hold_valid & rq_rdy[0];

  assign in_master_wvalid    = rq_vld[REQ_DEPTH] & rq_dat[REQ_DEPTH].wvalid;
  assign in_master_arvalid   = rq_vld[REQ_DEPTH] & rq_dat[REQ_DEPTH].arvalid;
  assign in_master_waddr     = rq_dat[REQ_DEPTH].waddr;
  assign in_master_wdata     = rq_dat[REQ_DEPTH].wdata;
  assign in_master_raddr     = rq_dat[REQ_DEPTH].raddr;
  assign in_master_node_addr = rq_dat[REQ_DEPTH].node_addr;

  assign rs_vld[0]         = in_master_rvalid;
  assign rs_dat[0]         = in_master_rdata;
  assign rs_rdy[RSP_DEPTH] = in_slave_rready;
  assign in_master_rready  = rs_rdy[0];
  assign in_slave_rvalid   = rs_vld[RSP_DEPTH];
  assign in_slave_rdata    = rs_dat[RSP_DEPTH];

  for (genvar i = 0; i < REQ_DEPTH; i++) begin : g_rq
    ps_if_skid #(.W($bits(req_t))) u_stg (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rq_vld[i]),
      .in_ready  (rq_rdy[i]),
      .in_data   (rq_dat[i]),
      .out_valid (rq_vld[i+1]),
      .out_ready (rq_rdy[i+1]),
      .out_data  (rq_dat[i+1])
    );
  end

  for (genvar i = 0; i < RSP_DEPTH; i++) begin : g_rs
    ps_if_skid #(.W(DW)) u_stg (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rs_vld[i]),
      .in_ready  (rs_rdy[i]),
      .in_data   (rs_dat[i]),
      .out_valid (rs_vld[i+1]),
      .out_ready (rs_rdy[i+1]),
      .out_data  (rs_dat[i+1])
    );
  end

  // wresp has no handshake, so it rides a plain delay line that stalls never touch
  if (RSP_DEPTH == 0) begin : g_wresp_wire
    assign in_slave_wresp = in_master_wresp;
  end else begin : g_wresp_pipe
    logic [RSP_DEPTH-1:0] wresp_pipe;
    always_ff @(posedge clk) begin
      if (rst) wresp_pipe <= '0;
      else     wresp_pipe <= (wresp_pipe << 1) | RSP_DEPTH'(in_master_wresp);
    end
    assign in_slave_wresp = wresp_pipe[RSP_DEPTH-1];
  end

  // a stage holds a beat exactly when its output valid is up; index 0 is the raw input
  assign busy = (|(rq_vld >> 1)) | (|(rs_vld >> 1));

`ifdef PS_IF_PIPE_STATS_EN
  logic [31:0] req_cnt, rsp_cnt, stall_cnt;
  logic        req_acc, rsp_dlv, req_stall;

  assign req_acc   = rq_vld[0] & in_slave_wready;
  assign rsp_dlv   = in_slave_rvalid & in_slave_rready;
  assign req_stall = (in_master_wvalid | in_master_arvalid) & ~in_master_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_cnt   <= '0;
      rsp_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (req_acc)   req_cnt   <= req_cnt + 32'd1;
      if (rsp_dlv)   rsp_cnt   <= rsp_cnt + 32'd1;
      if (req_stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stat_req_cnt   = req_cnt;
  assign stat_rsp_cnt   = rsp_cnt;
  assign stat_stall_cnt = stall_cnt;
`else
  assign stat_req_cnt   = '0;
  assign stat_rsp_cnt   = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: doc/ps_if_pipe.md
# ps_if_pipe

Parametrised, back-pressure-correct pipeline slice for the `ps_if` bus, with independent stage counts on the request path (slave → master) and the response path (master → slave). Each stage is a two-entry skid register, so every ready is registered, throughput stays at one beat per cycle, and no beat is dropped or duplicated under stalls. It is placed between `ps_if` masters and node-side slaves wherever timing closure needs registered cuts on long routes.

## Interface
- `REQ_DEPTH`, default 1: request-path stages, range 0..8. 0 is a combinational pass-through.
- `RSP_DEPTH`, default 1: response-path stages, range 0..8. 0 is a combinational pass-through.
- `clk` input, 1: the single clock.
- `rst` input, 1: reset, synchronous and active-high.
- `hold_valid` input, 1: request admission enable. Low blocks new requests from entering.
- `in_slave` ps_if.slave, —: upstream side.
- `in_master` ps_if.master, —: downstream side.
- `busy` output, 1: any stage on either path holds a beat.
- `stat_req_cnt` output, 32: requests accepted at `in_slave`.
- `stat_rsp_cnt` output, 32: responses delivered at `in_slave`.
- `stat_stall_cnt` output, 32: cycles with a request beat pending at `in_master` and `in_master.wready` low.

## Operation
- **Request beat**
  - Contents: {`wvalid`, `arvalid`, `waddr`, `wdata`, `raddr`, `node_addr`}.
  - Beat valid = `wvalid | arvalid`.
  - Both flags set in one beat are carried together, unchanged.
  - `in_slave.wready` is the shared request ready.
- **Admission**
  - A beat enters when `hold_valid & beat_valid & in_slave.wready`.
  - `in_slave.wready` = `hold_valid & stage0_can_accept`. It is 0 while `hold_valid` is low.
- **Response beat**
  - Contents: {`rdata`}, valid `rvalid`, ready `rready`.
  - It moves master → slave through `RSP_DEPTH` stages.
  - Downstream sees `in_master.rready` = stage-0 can-accept.
- **`wresp`**
  - No handshake.
  - Delayed by exactly `RSP_DEPTH` flops.
  - Every pulse is preserved independently of `rready` stalls.
- **Skid stage state**: `EMPTY`, `ONE` (main full), `TWO` (main + skid full).
  - `EMPTY`, in-beat → `ONE`.
  - `ONE`, in-beat and no out-take → `TWO`.
  - `ONE`, out-take and no in-beat → `EMPTY`.
  - `TWO`, out-take → `ONE`. No input is accepted in `TWO`.
  - `ONE` with simultaneous in and out: stays `ONE`, and main loads the new beat.
- **Ordering**: strict FIFO per path. The skid entry drains into main before any newer beat.
- **Ready timing**: upstream ready of a stage = registered `(state != TWO)`. There is no combinational path ready→ready.
- **`busy`**: OR of all stage states `!= EMPTY`.

## Timing
- **Latency**
  - Request latency = `REQ_DEPTH` cycles, from acceptance to valid at `in_master` when unstalled.
  - Response latency = `RSP_DEPTH` cycles.
- **Throughput**: one beat per cycle per path at sustained ready.
- **Buffering**: at most 2 × DEPTH beats are buffered per path.
- **Output stability**: outputs hold stable while valid and not ready (AXI-style stability).
- **Reset values**
  - All stages go to `EMPTY`.
  - All valids, `wresp`, and `busy` go to 0.
  - Data outputs go to 0.
  - Counters go to 0.
  - Readies go to 0 in the reset cycle and become 1 (subject to `hold_valid`) the cycle after `rst` falls.
- **Reset mid-operation**: in-flight beats are discarded. No partial beat is emitted.
- **DEPTH = 0**
  - Pure wires, with `hold_valid` gating the valids.
  - Readies pass through combinationally.
  - `busy` is 0.
- **Counters**: 32-bit, wrap modulo 2^32.

## Configuration
- `PS_IF_PIPE_STATS_EN` defined: the three `stat_*` counters are implemented.
- Macro undefined: the `stat_*` ports remain and are tied to 0. No counter logic is synthesised.

## Test plan
- `REQ_DEPTH=2`, write addr 0x10 data 0xA5, `wready` always 1 → the beat appears at `in_master` exactly 2 cycles later with identical fields. `stat_req_cnt`=1.
- `REQ_DEPTH=3`, 8 back-to-back writes, downstream `wready` low for cycles 3–6 → all 8 beats arrive in order with no loss or duplicate. `stat_stall_cnt` equals the stall cycles observed with a beat pending.
- `hold_valid=0` with `wvalid=1` for 5 cycles → `in_slave.wready`=0 and nothing is forwarded. Raising `hold_valid` admits the beat on the next edge.
- `RSP_DEPTH=2`, 4 reads returning rdata 1..4, slave `rready` toggled 1/0 → rdata 1,2,3,4 are delivered in order. A `wresp` pulse arrives exactly 2 cycles later despite the stalls.
- `rst` asserted with 3 beats buffered → the next cycle shows `busy`=0, all valids 0, and counters 0. No stale beat appears after release.
- Both `REQ_DEPTH=0` and `RSP_DEPTH=0` → the output mirrors the input in the same cycle on both paths.
